hdmi_i2c_target: RTL and testbench

- I2C target (responder) at the far end of the HDMI controller's I2C master; models the HDMI transmitter chip's configuration port in simulation and FPGA loopback.
- Holds a 256x8 register file addressed by an 8-bit sub-address with auto-increment; reports every master byte-write to the host through a valid/ready write-event port.
- Open-drain signalling through externally instantiated IO buffers (I/O/T triplets).

---
 rtl/hdmi_i2c_target.sv | 211 +++++++++++++++++++++
 tb/tb_hdmi_i2c_target.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_i2c_target.sv
// hdmi_i2c_target: I2C target with a 256x8 register file, auto-incrementing
// sub-address pointer and a valid/ready write-event port to the host.
// Optional build macro HDMI_I2C_TARGET_CLOCK_STRETCH_EN: hold SCL low after a
// data-byte ACK while a write event is still unaccepted.
module hdmi_i2c_target #(
    parameter logic [6:0]  C_DEV_ADDR     = 7'h39,
    parameter int unsigned C_FILTER_DEPTH = 4
) (
    input  logic       ACLK,
    input  logic       RST,
    input  logic       SCL_I,
    output logic       SCL_O,
    output logic       SCL_T,
    input  logic       SDA_I,
    output logic       SDA_O,
    output logic       SDA_T,
    output logic       WR_VALID,
    input  logic       WR_READY,
    output logic [7:0] WR_ADDR,
    output logic [7:0] WR_DATA,
    output logic       BUSY
);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_SUB, S_SUB_ACK,
        S_WRITE, S_W_ACK, S_READ, S_R_ACK, S_WAIT
    } state_t;

    localparam logic [3:0] FILT_LAST = 4'(C_FILTER_DEPTH - 1);

    // index 1 = SCL, index 0 = SDA
    logic [1:0] sync0, sync1, filt, filt_q;
    logic [3:0] fcnt [2];

    state_t     state, state_n;
    logic [2:0] bitcnt;
    logic [7:0] shreg;
    logic [7:0] ptr;
    logic [7:0] ptr_inc;
    logic [7:0] byte_in;
    logic       sda_t_q;
    logic       busy_q;
    logic       wr_valid_q;
    logic [7:0] wr_addr_q, wr_data_q;
    logic [7:0] regs [256];

    logic scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det, last_bit;

    assign scl_f     = filt[1];
    assign sda_f     = filt[0];
    assign scl_rise  = filt[1] & ~filt_q[1];
    assign scl_fall  = ~filt[1] & filt_q[1];
    assign start_det = filt_q[0] & ~filt[0] & scl_f & filt_q[1];
    assign stop_det  = ~filt_q[0] & filt[0] & scl_f & filt_q[1];
    assign byte_in   = {shreg[6:0], sda_f};
    assign ptr_inc   = ptr + 8'd1;
    assign last_bit  = (bitcnt == 3'd7);

    assign SCL_O    = 1'b0;
    assign SDA_O    = 1'b0;
    assign SDA_T    = sda_t_q;
    assign BUSY     = busy_q;
    assign WR_VALID = wr_valid_q;
    assign WR_ADDR  = wr_addr_q;
    assign WR_DATA  = wr_data_q;

    // Synchronize SCL/SDA and accept a level change only after C_FILTER_DEPTH equal samples
    always_ff @(posedge ACLK) begin
        if (RST) begin
            sync0  <= '1;
            sync1  <= '1;
            filt   <= '1;
            filt_q <= '1;
            for (int unsigned i = 0; i < 2; i++) fcnt[i] <= '0;
        end else begin
            sync0  <= {SCL_I, SDA_I};
            sync1  <= sync0;
            filt_q <= filt;
            for (int unsigned i = 0; i < 2; i++) begin
                if (sync1[i] == filt[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == FILT_LAST) begin
                    filt[i] <= sync1[i];
                    fcnt[i] <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + 4'd1;
                end
            end
        end
    end

    // State register
    always_ff @(posedge ACLK) begin
        if (RST) state <= S_IDLE;
        else     state <= state_n;
    end

    // Next state: START/STOP override bit events; bits advance on SCL rise
    always_comb begin
        state_n = state;
        if (start_det) begin
            state_n = S_ADDR;
        end else if (stop_det) begin
            state_n = S_IDLE;
        end else if (scl_rise) begin
            case (state)
                S_ADDR:     if (last_bit) state_n = (byte_in[7:1] == C_DEV_ADDR) ? S_ADDR_ACK : S_IDLE;
                S_ADDR_ACK: state_n = shreg[0] ? S_READ : S_SUB;
                S_SUB:      if (last_bit) state_n = S_SUB_ACK;
                S_SUB_ACK:  state_n = S_WRITE;
                S_WRITE:    if (last_bit) state_n = S_W_ACK;
                S_W_ACK:    state_n = S_WRITE;
                S_READ:     if (last_bit) state_n = S_R_ACK;
                S_R_ACK:    state_n = sda_f ? S_WAIT : S_READ;
                default:    state_n = state;
            endcase
        end
    end

    // Datapath: shift/count on SCL rise, SDA drive updated only on SCL fall
    always_ff @(posedge ACLK) begin
        if (RST) begin
            bitcnt     <= '0;
            shreg      <= '0;
            ptr        <= '0;
            sda_t_q    <= 1'b1;
            busy_q     <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            for (int unsigned i = 0; i < 256; i++) regs[i] <= '0;
        end else begin
            if (wr_valid_q && WR_READY) wr_valid_q <= 1'b0;
            if (start_det) begin
                bitcnt  <= '0;
                sda_t_q <= 1'b1;
            end else if (stop_det) begin
                busy_q  <= 1'b0;
                sda_t_q <= 1'b1;
            end else if (scl_rise) begin
                case (state)
                    S_ADDR: begin
                        shreg  <= byte_in;
                        bitcnt <= bitcnt + 3'd1;
                        if (last_bit && byte_in[7:1] == C_DEV_ADDR) busy_q <= 1'b1;
                    end
                    S_SUB: begin
                        shreg  <= byte_in;
                        bitcnt <= bitcnt + 3'd1;
                        if (last_bit) ptr <= byte_in;
                    end
                    S_WRITE: begin
                        shreg  <= byte_in;
                        bitcnt <= bitcnt + 3'd1;
                        if (last_bit) begin
                            regs[ptr]  <= byte_in;
                            wr_addr_q  <= ptr;
                            wr_data_q  <= byte_in;
                            wr_valid_q <= 1'b1;
                            ptr        <= ptr_inc;
                        end
                    end
                    S_ADDR_ACK: if (shreg[0]) shreg <= regs[ptr];
                    S_READ:     bitcnt <= bitcnt + 3'd1;
                    S_R_ACK: begin
                        if (!sda_f) begin
                            ptr   <= ptr_inc;
                            shreg <= regs[ptr_inc];
                        end
                    end
                    default: ;
                endcase
            end else if (scl_fall) begin
                case (state)
                    S_ADDR_ACK, S_SUB_ACK, S_W_ACK: sda_t_q <= 1'b0;
                    S_READ: begin
                        sda_t_q <= shreg[7];
                        shreg   <= {shreg[6:0], 1'b0};
                    end
                    default: sda_t_q <= 1'b1;
                endcase
            end
        end
    end

`ifdef HDMI_I2C_TARGET_CLOCK_STRETCH_EN
    logic stretch_arm, scl_hold;

    // Arm on the W_ACK rise; on the following fall hold SCL low until the event is taken
    always_ff @(posedge ACLK) begin
        if (RST) begin
            stretch_arm <= 1'b0;
            scl_hold    <= 1'b0;
        end else begin
            if (start_det || stop_det || scl_fall)
                stretch_arm <= 1'b0;
            else if (scl_rise && state == S_W_ACK)
                stretch_arm <= 1'b1;
            if (scl_hold)
                scl_hold <= wr_valid_q & ~WR_READY;
            else if (scl_fall && stretch_arm && wr_valid_q && !WR_READY)
                scl_hold <= 1'b1;
        end
    end

    assign SCL_T = ~scl_hold;
`else
    assign SCL_T = 1'b1;
`endif

endmodule

// File: tb/tb_hdmi_i2c_target.sv
// Directed bench for hdmi_i2c_target: a bit-banged I2C master drives the bus,
// expected ACKs/bytes/write events go into queues and a monitor checks them.
module tb_hdmi_i2c_target;

    localparam int Q = 10;  // quarter SCL period in ACLK cycles

    logic       ACLK = 1'b0;
    logic       RST = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       WR_READY = 1'b1;
    logic       SCL_I, SDA_I, SCL_O, SCL_T, SDA_O, SDA_T;
    logic       WR_VALID, BUSY;
    logic [7:0] WR_ADDR, WR_DATA;
    logic       scl_line, sda_line;

    assign scl_line = scl_m & (SCL_T ? 1'b1 : SCL_O);
    assign sda_line = sda_m & (SDA_T ? 1'b1 : SDA_O);
    assign SCL_I = scl_line;
    assign SDA_I = sda_line;

    hdmi_i2c_target #(.C_DEV_ADDR(7'h39), .C_FILTER_DEPTH(4)) dut (
        .ACLK(ACLK), .RST(RST),
        .SCL_I(SCL_I), .SCL_O(SCL_O), .SCL_T(SCL_T),
        .SDA_I(SDA_I), .SDA_O(SDA_O), .SDA_T(SDA_T),
        .WR_VALID(WR_VALID), .WR_READY(WR_READY),
        .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .BUSY(BUSY)
    );

    always #5 ACLK = ~ACLK;

    typedef struct { string name; logic [7:0] val; } bus_exp_t;
    typedef struct { logic [7:0] a; logic [7:0] d; } wr_exp_t;

    bus_exp_t   exp_bus [$];
    logic [7:0] obs_bus [$];
    wr_exp_t    exp_wr  [$];

    int n_pass = 0;
    int n_total = 0;
    logic watch = 1'b0;
    logic sda_low_seen = 1'b0;
    logic scl_t_low_seen = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic fail_now(input string name, input logic [31:0] act);
        n_total++;
        $display("FAIL %s: got 0x%0h, expected nothing here", name, act);
    endtask

    task automatic expect_bus(input string name, input logic [7:0] v);
        bus_exp_t e;
        e.name = name;
        e.val  = v;
        exp_bus.push_back(e);
    endtask

    task automatic expect_wr(input logic [7:0] a, input logic [7:0] d);
        wr_exp_t e;
        e.a = a;
        e.d = d;
        exp_wr.push_back(e);
    endtask

    // Scoreboard monitor: write-event handshakes and bus observations
    always @(negedge ACLK) begin
        if (!RST && WR_VALID && WR_READY) begin
            if (exp_wr.size() == 0) begin
                fail_now("wr_unexpected", {16'h0, WR_ADDR, WR_DATA});
            end else begin
                wr_exp_t e;
                e = exp_wr.pop_front();
                check("wr_event", {WR_ADDR, WR_DATA}, {16'h0, e.a, e.d});
            end
        end
        if (obs_bus.size() != 0) begin
            logic [7:0] o;
            o = obs_bus.pop_front();
            if (exp_bus.size() == 0) begin
                fail_now("bus_unexpected", {24'h0, o});
            end else begin
                bus_exp_t e;
                e = exp_bus.pop_front();
                check(e.name, {24'h0, o}, {24'h0, e.val});
            end
        end
        if (watch && SDA_T === 1'b0) sda_low_seen = 1'b1;
        if (!RST && SCL_T !== 1'b1) scl_t_low_seen = 1'b1;
    end

    initial begin
        repeat (90000) @(posedge ACLK);
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge ACLK);
        #1;
    endtask

    task automatic scl_up();
        int k;
        scl_m = 1'b1;
        k = 0;
        while (scl_line !== 1'b1 && k < 2000) begin
            cyc(1);
            k++;
        end
        if (k >= 2000) fail_now("scl_release_timeout", k);
    endtask

    task automatic send_bit(input logic b, input logic glitch, output logic rd);
        cyc(Q);
        sda_m = b;
        cyc(Q);
        scl_up();
        if (glitch) begin
            cyc(3);
            sda_m = ~b;
            cyc(2);
            sda_m = b;
            cyc(Q - 5);
        end else begin
            cyc(Q);
        end
        rd = sda_line;
        cyc(Q);
        scl_m = 1'b0;
    endtask

    task automatic i2c_start();
        if (scl_m == 1'b0) begin
            cyc(Q);
            sda_m = 1'b1;
            cyc(Q);
            scl_up();
        end
        cyc(Q);
        sda_m = 1'b0;
        cyc(Q);
        scl_m = 1'b0;
    endtask

    task automatic i2c_stop();
        cyc(Q);
        sda_m = 1'b0;
        cyc(Q);
        scl_up();
        cyc(Q);
        sda_m = 1'b1;
        cyc(2 * Q);
    endtask

    // Observed value pushed is the 9th-bit SDA level (0 = ACK)
    task automatic write_byte(input logic [7:0] d, input logic [7:0] gmask);
        logic rd;
        for (int i = 7; i >= 0; i--) send_bit(d[i], gmask[i], rd);
        send_bit(1'b1, 1'b0, rd);
        obs_bus.push_back({7'h0, rd});
    endtask

    task automatic read_byte(input logic ack);
        logic rd;
        logic [7:0] d;
        d = '0;
        for (int i = 0; i < 8; i++) begin
            send_bit(1'b1, 1'b0, rd);
            d = {d[6:0], rd};
        end
        send_bit(~ack, 1'b0, rd);
        obs_bus.push_back(d);
    endtask

    task automatic wr_seq(input string tag, input logic [7:0] d);
        expect_bus(tag, 8'h00);
        write_byte(d, 8'h00);
    endtask

    initial begin
        logic rd;
        cyc(5);
        RST = 1'b0;
        cyc(2);
        check("rst_sda_t", SDA_T, 1);
        check("rst_scl_t", SCL_T, 1);
        check("rst_wr_valid", WR_VALID, 0);
        check("rst_wr_addr", WR_ADDR, 0);
        check("rst_wr_data", WR_DATA, 0);
        check("rst_busy", BUSY, 0);

        // write 0xA5, 0x5A from sub-address 0x10
        i2c_start();
        wr_seq("ack_addr_w", 8'h72);
        wr_seq("ack_sub_10", 8'h10);
        expect_wr(8'h10, 8'hA5);
        wr_seq("ack_data_a5", 8'hA5);
        expect_wr(8'h11, 8'h5A);
        wr_seq("ack_data_5a", 8'h5A);
        check("busy_in_write", BUSY, 1);
        i2c_stop();
        check("busy_after_stop", BUSY, 0);

        // read back two bytes through a repeated START
        i2c_start();
        wr_seq("ack_addr_w2", 8'h72);
        wr_seq("ack_sub_10b", 8'h10);
        i2c_start();
        wr_seq("ack_addr_r", 8'h73);
        expect_bus("read_a5", 8'hA5);
        read_byte(1'b1);
        expect_bus("read_5a", 8'h5A);
        read_byte(1'b0);
        cyc(Q);
        check("sda_released_after_nack", SDA_T, 1);
        i2c_stop();

        // foreign address is ignored, next START re-arms
        i2c_start();
        sda_low_seen = 1'b0;
        watch = 1'b1;
        expect_bus("nack_addr_74", 8'h01);
        write_byte(8'h74, 8'h00);
        watch = 1'b0;
        check("mismatch_sda_never_low", sda_low_seen, 0);
        check("mismatch_busy", BUSY, 0);
        check("mismatch_no_wr_valid", WR_VALID, 0);
        i2c_start();
        wr_seq("ack_after_mismatch", 8'h72);
        i2c_stop();

        // pointer wrap 0xFF -> 0x00, then read back across the wrap
        i2c_start();
        wr_seq("ack_addr_wrap", 8'h72);
        wr_seq("ack_sub_ff", 8'hFF);
        expect_wr(8'hFF, 8'h11);
        wr_seq("ack_data_11", 8'h11);
        expect_wr(8'h00, 8'h22);
        wr_seq("ack_data_22", 8'h22);
        i2c_stop();
        i2c_start();
        wr_seq("ack_addr_wrap2", 8'h72);
        wr_seq("ack_sub_ff2", 8'hFF);
        i2c_start();
        wr_seq("ack_addr_wrap_r", 8'h73);
        expect_bus("read_ff_11", 8'h11);
        read_byte(1'b1);
        expect_bus("read_00_22", 8'h22);
        read_byte(1'b0);
        i2c_stop();

        // 2-cycle SDA glitches while SCL high: fake STOP on bit7, fake START on bit2
        i2c_start();
        wr_seq("ack_addr_glitch", 8'h72);
        wr_seq("ack_sub_30", 8'h30);
        expect_wr(8'h30, 8'h3C);
        expect_bus("ack_data_3c_glitched", 8'h00);
        write_byte(8'h3C, 8'b1000_0100);
        check("busy_after_glitch", BUSY, 1);
        i2c_stop();

`ifdef HDMI_I2C_TARGET_CLOCK_STRETCH_EN
        // SCL held low while the write event waits for the host
        WR_READY = 1'b0;
        i2c_start();
        wr_seq("ack_addr_stretch", 8'h72);
        wr_seq("ack_sub_40", 8'h40);
        expect_wr(8'h40, 8'h77);
        wr_seq("ack_data_77", 8'h77);
        begin
            logic held;
            held = 1'b1;
            cyc(10);
            for (int i = 0; i < 200; i++) begin
                if (SCL_T !== 1'b0) held = 1'b0;
                cyc(1);
            end
            check("scl_held_200", held, 1);
        end
        check("stretch_wr_valid_pending", WR_VALID, 1);
        WR_READY = 1'b1;
        cyc(1);
        check("scl_released_after_hs", SCL_T, 1);
        expect_wr(8'h41, 8'h88);
        wr_seq("ack_data_88", 8'h88);
        i2c_stop();
`else
        // without stretching a pending event is overwritten by the next one
        WR_READY = 1'b0;
        i2c_start();
        wr_seq("ack_addr_ovr", 8'h72);
        wr_seq("ack_sub_20", 8'h20);
        wr_seq("ack_data_01", 8'h01);
        wr_seq("ack_data_02", 8'h02);
        i2c_stop();
        check("ovr_wr_valid_pending", WR_VALID, 1);
        expect_wr(8'h21, 8'h02);
        WR_READY = 1'b1;
        cyc(3);
        check("ovr_wr_valid_cleared", WR_VALID, 0);
`endif

        // reset in the middle of a read byte
        i2c_start();
        wr_seq("ack_addr_rst", 8'h72);
        wr_seq("ack_sub_rst", 8'h10);
        i2c_start();
        wr_seq("ack_addr_rst_r", 8'h73);
        send_bit(1'b1, 1'b0, rd);
        check("rst_read_bit7", rd, 1);
        cyc(Q);
        check("rst_read_drives_bit6", SDA_T, 0);
        RST = 1'b1;
        cyc(1);
        check("rst_mid_sda_t", SDA_T, 1);
        check("rst_mid_busy", BUSY, 0);
        cyc(2);
        RST = 1'b0;
        scl_m = 1'b1;
        sda_m = 1'b1;
        cyc(4 * Q);
        i2c_start();
        wr_seq("ack_addr_post_rst", 8'h72);
        wr_seq("ack_sub_post_rst", 8'h10);
        i2c_start();
        wr_seq("ack_addr_post_rst_r", 8'h73);
        expect_bus("read_cleared_reg", 8'h00);
        read_byte(1'b0);
        i2c_stop();

        cyc(5);
`ifndef HDMI_I2C_TARGET_CLOCK_STRETCH_EN
        check("scl_t_constant", scl_t_low_seen, 0);
`endif
        check("wr_queue_drained", exp_wr.size(), 0);
        check("bus_queue_drained", exp_bus.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
